sample_merge_16: RTL

- Producer side of the averaging stage's sample interface: assembles a byte stream from the ADC capture path into 16-bit signed samples.
- Emits each sample on data_o with a one-cycle merge_finished_o strobe; this strobe drives merge_finished_i of the downstream DC-removal averager.
- Handles byte order, offset-binary to two's-complement conversion, resynchronisation on a frame marker, and timeout of half-received samples.

---
 rtl/sample_merge_16.sv | 100 ++++++++++
 1 files changed

// File: rtl/sample_merge_16.sv
// sample_merge_16: assembles pairs of bytes from the ADC capture path into
// 16-bit signed samples. Handles byte order, offset-binary conversion,
// resync on a frame marker and timeout of a half-received sample.
module sample_merge_16 #(
    parameter int WIDTH      = 16,
    parameter int BYTE_W     = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit OFFSET_BIN = 1'b1,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     byte_valid_i,
    input  logic [BYTE_W-1:0]        byte_i,
    input  logic                     frame_i,
    output logic signed [WIDTH-1:0]  data_o,
    output logic                     merge_finished_o,
    output logic                     err_o
);

    // A sample is exactly two bytes; anything else cannot be assembled.
    if (WIDTH != 2*BYTE_W) begin : g_bad_width
        $error("sample_merge_16: WIDTH must equal 2*BYTE_W");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("sample_merge_16: TIMEOUT must be in 1..255");
    end

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t              state;
    logic [BYTE_W-1:0]   hold;
    logic [7:0]          timer;
    logic [WIDTH-1:0]    merged;

    // Order held/incoming bytes into {hi,lo} and convert offset binary.
    always_comb begin
        merged = MSB_FIRST ? {hold, byte_i} : {byte_i, hold};
        if (OFFSET_BIN)
            merged[WIDTH-1] = ~merged[WIDTH-1];
    end

    // Byte-pair FSM; outputs are registered and strobes last one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            hold             <= '0;
            timer            <= '0;
            data_o           <= '0;
            merge_finished_o <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            merge_finished_o <= 1'b0;
            err_o            <= 1'b0;
            if (!start_i) begin
                // Disable wins over everything; a partial byte is silently lost.
                state <= IDLE;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: state <= FIRST;
                    FIRST: begin
                        if (byte_valid_i) begin
                            hold  <= byte_i;
                            timer <= '0;
                            state <= SECOND;
                        end
                    end
                    SECOND: begin
                        if (byte_valid_i && !frame_i) begin
                            data_o           <= merged;
                            merge_finished_o <= 1'b1;
                            state            <= FIRST;
                        end else if (byte_valid_i) begin
                            // Frame marker mid-sample: restart with this byte.
                            err_o <= 1'b1;
                            hold  <= byte_i;
                            timer <= '0;
                        end else if (timer == TO_LAST) begin
                            err_o <= 1'b1;
                            timer <= '0;
                            state <= FIRST;
                        end else if (timer != 8'hFF) begin
                            timer <= timer + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
